// File: rtl/execute_hazard_ctrl_if.sv
// Pipeline hazard control bundle: pipeline status in, per-stage stall/flush out.
// Optional perf counters appear when EXECUTE_HAZARD_CTRL_PERF_EN is defined.
interface execute_hazard_ctrl_if;
  logic       decode_valid_in;
  logic [8:0] decode_rs1_in;
  logic [8:0] decode_rs2_in;
  logic       decode_rs1_read_in;
  logic       decode_rs2_read_in;
  logic       execute_valid_in;
  logic       execute_mem_read_in;
  logic [8:0] execute_rd_in;
  logic       execute_rd_write_in;
  logic       mem_valid_in;
  logic       mem_fence_in;
  logic       mem_mispredict_in;
  logic       dbus_busy_in;
  logic       dbus_idle_in;
  logic       fetch_stall_out;
  logic       decode_stall_out;
  logic       execute_stall_out;
  logic       mem_stall_out;
  logic       fetch_flush_out;
  logic       decode_flush_out;
  logic       execute_flush_out;
  logic       mem_flush_out;
  logic       bus_timeout_out;
  logic [1:0] state_out;
`ifdef EXECUTE_HAZARD_CTRL_PERF_EN
  logic [63:0] stall_cycles_out;
  logic [63:0] flush_events_out;
`endif

  // Pipeline side: drives status, receives controls.
  modport master (
    output decode_valid_in, decode_rs1_in, decode_rs2_in,
    output decode_rs1_read_in, decode_rs2_read_in,
    output execute_valid_in, execute_mem_read_in, execute_rd_in, execute_rd_write_in,
    output mem_valid_in, mem_fence_in, mem_mispredict_in, dbus_busy_in, dbus_idle_in,
    input  fetch_stall_out, decode_stall_out, execute_stall_out, mem_stall_out,
    input  fetch_flush_out, decode_flush_out, execute_flush_out, mem_flush_out,
    input  bus_timeout_out, state_out
`ifdef EXECUTE_HAZARD_CTRL_PERF_EN
    , input stall_cycles_out, flush_events_out
`endif
  );

  // Controller side.
  modport slave (
    input  decode_valid_in, decode_rs1_in, decode_rs2_in,
    input  decode_rs1_read_in, decode_rs2_read_in,
    input  execute_valid_in, execute_mem_read_in, execute_rd_in, execute_rd_write_in,
    input  mem_valid_in, mem_fence_in, mem_mispredict_in, dbus_busy_in, dbus_idle_in,
    output fetch_stall_out, decode_stall_out, execute_stall_out, mem_stall_out,
    output fetch_flush_out, decode_flush_out, execute_flush_out, mem_flush_out,
    output bus_timeout_out, state_out
`ifdef EXECUTE_HAZARD_CTRL_PERF_EN
    , output stall_cycles_out, flush_events_out
`endif
  );
endinterface

// File: rtl/execute_hazard_ctrl.sv
// Central stall/flush controller for the five-stage core (load-use, mispredict,
// bus wait with watchdog, fence drain). EXECUTE_HAZARD_CTRL_PERF_EN adds perf counters.
module execute_hazard_ctrl #(
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  execute_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FENCE    = 2'd2,
    ST_TIMEOUT  = 2'd3
  } state_t;

  localparam logic       TIMEOUT_EN  = (TIMEOUT != 0);
  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  // Stage vectors: bit 0 fetch, 1 decode, 2 execute, 3 memory.
  localparam logic [3:0] STAGES_ALL   = 4'b1111;
  localparam logic [3:0] STAGES_FRONT = 4'b0111;
  localparam logic [3:0] STAGES_FD    = 4'b0011;
  localparam logic [3:0] STAGE_EX     = 4'b0100;

  state_t     state_reg, state_next;
  logic [7:0] count_reg, count_next, count_inc;
  logic       timeout_reg;
  logic       load_use, mispredict, busy, fence;
  logic [3:0] stall_next, flush_next;
  logic [3:0] stall_gated, flush_gated;

  always_comb begin
    load_use = bus.decode_valid_in & bus.execute_valid_in & bus.execute_mem_read_in
             & bus.execute_rd_write_in & (|bus.execute_rd_in)
             & ((bus.decode_rs1_read_in & (bus.decode_rs1_in == bus.execute_rd_in))
              | (bus.decode_rs2_read_in & (bus.decode_rs2_in == bus.execute_rd_in)));
    mispredict = bus.mem_valid_in & bus.mem_mispredict_in;
    busy       = bus.mem_valid_in & bus.dbus_busy_in;
    fence      = bus.mem_valid_in & bus.mem_fence_in;
    count_inc  = (count_reg == 8'hFF) ? 8'hFF : count_reg + 8'd1;
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    stall_next = 4'b0000;
    flush_next = 4'b0000;
    case (state_reg)
      ST_RUN: begin
        if (mispredict) begin
          flush_next = STAGES_FRONT;
        end else if (busy) begin
          stall_next = STAGES_ALL;
          count_next = 8'd1;
          // A one-cycle budget is already spent by this entry cycle.
          state_next = (TIMEOUT_EN && TIMEOUT_CNT == 8'd1) ? ST_TIMEOUT : ST_MEM_WAIT;
        end else if (fence) begin
          stall_next = STAGES_ALL;
          state_next = ST_FENCE;
        end else if (load_use) begin
          stall_next = STAGES_FD;
          flush_next = STAGE_EX;
        end
      end
      ST_MEM_WAIT: begin
        if (busy) begin
          stall_next = STAGES_ALL;
          count_next = count_inc;
          if (TIMEOUT_EN && count_inc == TIMEOUT_CNT) begin
            state_next = ST_TIMEOUT;
          end
        end else begin
          count_next = 8'd0;
          state_next = ST_RUN;
          if (load_use) begin
            stall_next = STAGES_FD;
            flush_next = STAGE_EX;
          end
        end
      end
      ST_FENCE: begin
        if (!bus.dbus_idle_in) begin
          stall_next = STAGES_ALL;
        end else begin
          flush_next = STAGES_FRONT;
          state_next = ST_RUN;
        end
      end
      ST_TIMEOUT: begin
        flush_next = STAGES_ALL;
        count_next = 8'd0;
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_RUN;
      count_reg   <= 8'd0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      timeout_reg <= (state_next == ST_TIMEOUT);
    end
  end

  // Controls are combinational, so they must be forced low while reset is held.
  for (genvar gi = 0; gi < 4; gi++) begin : g_gate
    assign stall_gated[gi] = stall_next[gi] & ~reset;
    assign flush_gated[gi] = flush_next[gi] & ~reset;
  end

  assign bus.fetch_stall_out   = stall_gated[0];
  assign bus.decode_stall_out  = stall_gated[1];
  assign bus.execute_stall_out = stall_gated[2];
  assign bus.mem_stall_out     = stall_gated[3];
  assign bus.fetch_flush_out   = flush_gated[0];
  assign bus.decode_flush_out  = flush_gated[1];
  assign bus.execute_flush_out = flush_gated[2];
  assign bus.mem_flush_out     = flush_gated[3];
  assign bus.bus_timeout_out   = timeout_reg;
  assign bus.state_out         = state_reg;

`ifdef EXECUTE_HAZARD_CTRL_PERF_EN
  logic [63:0] stall_cycles_reg, flush_events_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_reg <= 64'd0;
      flush_events_reg <= 64'd0;
    end else begin
      if (|stall_gated) stall_cycles_reg <= stall_cycles_reg + 64'd1;
      if (|flush_gated) flush_events_reg <= flush_events_reg + 64'd1;
    end
  end

  assign bus.stall_cycles_out = stall_cycles_reg;
  assign bus.flush_events_out = flush_events_reg;
`endif
endmodule

// File: doc/execute_hazard_ctrl.md
# execute_hazard_ctrl

Central pipeline controller for the five-stage core. It generates the per-stage `stall_in`/`flush_in` controls for fetch, decode, execute and memory from four sources:
- load-use hazards on the execute output register;
- branch mispredicts resolved in the memory stage;
- data-bus wait states, guarded by a timeout watchdog;
- fence drains.

It sits beside `execute`, whose stall/flush pins it drives directly.

## Interface
- `TIMEOUT`, default 16: consecutive bus-busy cycles before the watchdog fires (1..255); 0 disables the watchdog.
- `clk` in 1: pipeline clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `decode_valid_in` in 1: decode output register holds a valid instruction.
- `decode_rs1_in`, `decode_rs2_in` in 9 each: source register ids of the instruction entering execute.
- `decode_rs1_read_in`, `decode_rs2_read_in` in 1 each: the corresponding source is actually read.
- `execute_valid_in` in 1: execute output register is valid.
- `execute_mem_read_in` in 1: execute output register holds a load.
- `execute_rd_in` in 9, `execute_rd_write_in` in 1: destination of the execute output register.
- `mem_valid_in` in 1: memory stage holds a valid instruction.
- `mem_fence_in` in 1: memory-stage instruction is a fence.
- `mem_mispredict_in` in 1: memory-stage branch resolved opposite to prediction.
- `dbus_busy_in` in 1: data bus has not completed the memory-stage access.
- `dbus_idle_in` in 1: store buffer empty and no bus transaction outstanding.
- `fetch_stall_out`, `decode_stall_out`, `execute_stall_out`, `mem_stall_out` out 1 each: per-stage hold.
- `fetch_flush_out`, `decode_flush_out`, `execute_flush_out`, `mem_flush_out` out 1 each: per-stage bubble insert.
- `bus_timeout_out` out 1: one-cycle pulse when the watchdog fires.
- `state_out` out 2: current FSM state.

## Operation
FSM states and encoding:
- RUN = 0, MEM_WAIT = 1, FENCE = 2, TIMEOUT = 3.
- Reset state is RUN; the busy counter (8 bit) resets to 0.

Hazard terms:
- `load_use` = `decode_valid_in` & `execute_valid_in` & `execute_mem_read_in` & `execute_rd_write_in` & |`execute_rd_in` & ((`decode_rs1_read_in` & rs1==rd) | (`decode_rs2_read_in` & rs2==rd)).
- `mispredict` = `mem_valid_in` & `mem_mispredict_in`.
- `busy` = `mem_valid_in` & `dbus_busy_in`.

RUN — condition priority, highest first:
1. `mispredict`: fetch, decode and execute flushes = 1; all stalls = 0; stay in RUN.
2. `busy`: all four stalls = 1; counter ← 1; go to MEM_WAIT.
3. `mem_valid_in` & `mem_fence_in`: all four stalls = 1; go to FENCE.
4. `load_use`: fetch and decode stalls = 1; execute flush = 1 (the load advances, a bubble follows it); stay in RUN.
5. Otherwise all controls are 0.

MEM_WAIT:
- While `busy`: all stalls = 1 and the counter increments.
- If `busy` is still high when the counter equals `TIMEOUT` (and `TIMEOUT` ≠ 0): go to TIMEOUT.
- When `busy` falls: stalls = 0 in that cycle; load-use is evaluated as in RUN; counter ← 0; go to RUN.
- Mispredict and fence are not evaluated in MEM_WAIT.

FENCE:
- While `dbus_idle_in` = 0: all stalls = 1.
- The first cycle with `dbus_idle_in` = 1: stalls = 0; fetch, decode and execute flushes = 1 (refetch after the fence); go to RUN.

TIMEOUT (lasts exactly one cycle):
- `bus_timeout_out` = 1; all four flushes = 1; all stalls = 0.
- Counter ← 0; go to RUN.

General rules:
- A stage is never given stall and flush together.
- `reset` asserted mid-operation forces RUN and counter 0 immediately; all outputs go to 0 while `reset` is high.

## Timing
- All stall/flush outputs are combinational from state and inputs, valid in the same cycle as the hazard. There is no added latency.
- `state_out`, the counter and `bus_timeout_out` are registered. `bus_timeout_out` is high only while in state TIMEOUT.
- Load-use costs exactly 1 bubble.
- A mispredict costs 3 flushed slots.
- With `TIMEOUT` = T and the bus busy forever: stalls are high for T cycles, then the TIMEOUT cycle occurs.
- Counter saturates at 255; it never wraps.

## Configuration
- `EXECUTE_HAZARD_CTRL_PERF_EN` defined:
  - Adds outputs `stall_cycles_out` (64 bit) and `flush_events_out` (64 bit), both reset to 0.
  - `stall_cycles_out` increments each cycle any stall is high.
  - `flush_events_out` increments each cycle any flush is high.
  - Both wrap modulo 2^64.
- Macro undefined: neither port nor the counters exist; all other behaviour is identical.

## Test plan
- Load-use: `execute` holds load rd=5; decode instruction reads rs2=5 → exactly one cycle of fetch/decode stall = 1 and execute flush = 1. With rd=0 instead → no controls asserted.
- Mispredict during a load-use: `mispredict` and `load_use` in the same cycle → only fetch/decode/execute flush = 1, no stalls, state stays 0.
- Bus wait: `dbus_busy_in` high for 3 cycles, `TIMEOUT`=16 → all stalls high for 3 cycles, `state_out`=1 for 3 cycles then 0, `bus_timeout_out` never pulses.
- Watchdog: `TIMEOUT`=4, bus busy forever → 4 stall cycles, then one cycle with `state_out`=3, `bus_timeout_out`=1 and all flushes 1, then RUN. With `TIMEOUT`=0 → stall indefinitely.
- Fence: fence in memory stage with `dbus_idle_in` low for 5 cycles → 5+1 stall cycles (entry cycle included), then one flush cycle on fetch/decode/execute, then `state_out`=0.
- Reset: assert `reset` during MEM_WAIT with counter=7 → `state_out`=0 and all outputs 0 asynchronously. After release with `dbus_busy_in`=1, the counter restarts from 1. Under `EXECUTE_HAZARD_CTRL_PERF_EN`, both counters read 0.
